audio_sample_fifo: RTL and testbench
====================================

AUDIO_SAMPLE_FIFO -- requirements
Module: audio_sample_fifo

Interface
REQ-001 Parameter AUDIO_BITS, default 12, bits per channel; stereo word is 2*AUDIO_BITS wide, left in upper half, right in lower half.
REQ-002 Parameter DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 stereo words; legal range 2..8.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 aclr_  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  producer offers in_sample this cycle.
REQ-006 in_sample  input  2*AUDIO_BITS  stereo word from producer.
REQ-007 in_ready  output  1  FIFO not full; write accepted on an edge where in_valid=1 and in_ready=1.
REQ-008 sink_ready  input  1  ready from the 44.1 kHz audio output stage.
REQ-009 out_wreq  output  1  one-cycle write request to the audio output stage.
REQ-010 out_sample  output  2*AUDIO_BITS  word presented with out_wreq, registered.
REQ-011 level  output  DEPTH_LOG2+1  current FIFO occupancy, 0..2**DEPTH_LOG2.
REQ-012 underrun  output  1  one-cycle pulse when a sample is sent with the FIFO empty.

Function
REQ-013 Storage SHALL be a circular buffer with DEPTH_LOG2-bit read/write pointers wrapping modulo depth; full when level = depth, empty when level = 0.
REQ-014 in_ready SHALL equal (level != depth) combinationally from registered level.
REQ-015 Read FSM states SHALL be PRIME, IDLE, PUSH, WAIT; reset state PRIME.
REQ-016 PRIME: out_wreq=0, no underrun; go to IDLE when level >= 2**(DEPTH_LOG2-1).
REQ-017 IDLE: when sink_ready=1, go to PUSH on the next edge, loading out_sample with FIFO head (pop) if non-empty, else with the underrun word and pulsing underrun in the PUSH cycle.
REQ-018 PUSH: out_wreq=1 for exactly this one cycle; unconditionally go to WAIT.
REQ-019 WAIT: out_wreq=0; return to IDLE only after sink_ready sampled 0 (one sample per ready period).
REQ-020 Underrun word without the macro SHALL be the last out_sample value (hold).
REQ-021 Simultaneous accepted write and pop SHALL leave level unchanged; pointers both advance.
REQ-022 Write while full SHALL be ignored (no pointer/level change, no corruption).
REQ-023 Write latency: a word accepted at edge N is poppable from edge N+1.
REQ-024 out_sample SHALL hold its value between PUSH cycles.

Reset
REQ-025 aclr_=0 SHALL immediately force: pointers 0, level 0, state PRIME, out_wreq 0, out_sample 0, underrun 0; in_ready becomes 1.
REQ-026 Reset mid-operation SHALL discard all buffered samples; no wreq until re-primed.
REQ-027 Storage array contents need not be reset.

Configuration
REQ-028 Macro AUDIO_FIFO_MUTE_ON_UNDERRUN_EN: when defined, the underrun word SHALL be midscale per channel ({1'b1, zeros} in each half, 0x800800 at AUDIO_BITS=12); when undefined, REQ-020 hold behaviour applies.

Verification
REQ-029 Reset, write 7 words with sink_ready=1 (depth 16) -> out_wreq stays 0, level=7; 8th write -> IDLE, first out_wreq carries word 1.
REQ-030 Write 16 words with sink_ready=0 -> level=16, in_ready=0; 17th in_valid ignored, level stays 16, read order 1..16 intact.
REQ-031 Prime, hold sink_ready=1 constant -> exactly one out_wreq, no further until sink_ready toggles 0->1.
REQ-032 Prime with 8 words, toggle sink_ready 9 times -> 9th wreq: underrun=1, out_sample = word 8 (macro off) or 0x800800 (macro on).
REQ-033 Write and pop on same edge at level=5 -> level stays 5, pointer wrap at index 15->0 preserves data order.
REQ-034 Assert aclr_ during WAIT with level=10 -> out_wreq=0, level=0, state PRIME, out_sample=0 asynchronously.

Source files
------------

// File: rtl/audio_sample_fifo_if.sv
// Stereo sample FIFO bus: producer write handshake, sink side pacing and
// the status outputs of audio_sample_fifo.
//
// Handshake: a word moves from producer to FIFO on a rising clk edge where
// in_valid=1 and in_ready=1; in_valid without in_ready is simply ignored.
// Toward the audio output stage, out_wreq is a one-cycle strobe with
// out_sample valid in the same cycle; one word is sent per high period
// of sink_ready.
interface audio_sample_fifo_if #(
  parameter int AUDIO_BITS = 12,
  parameter int DEPTH_LOG2 = 4
);
  logic                      in_valid;
  logic [2*AUDIO_BITS-1:0]   in_sample;
  logic                      in_ready;
  logic                      sink_ready;
  logic                      out_wreq;
  logic [2*AUDIO_BITS-1:0]   out_sample;
  logic [DEPTH_LOG2:0]       level;
  logic                      underrun;

  // Producer / environment side.
  modport master (
    output in_valid, in_sample, sink_ready,
    input  in_ready, out_wreq, out_sample, level, underrun
  );

  // FIFO side.
  modport slave (
    input  in_valid, in_sample, sink_ready,
    output in_ready, out_wreq, out_sample, level, underrun
  );
endinterface

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: circular buffer of stereo words (left in the upper
// half) feeding a 44.1 kHz output stage. A read FSM primes the buffer to
// half full, then sends one word per sink_ready period as a one-cycle
// out_wreq. When the buffer is empty at send time, an underrun word is sent
// and underrun pulses with it.
//
// Build option: define AUDIO_FIFO_MUTE_ON_UNDERRUN_EN to send midscale per
// channel on underrun; otherwise the previous out_sample is repeated.
module audio_sample_fifo #(
  parameter int AUDIO_BITS = 12,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 aclr_,
  audio_sample_fifo_if.slave   bus,
  output logic [1:0]           fsm_state
);

  localparam int W     = 2 * AUDIO_BITS;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LEVEL_PRIME = (DEPTH_LOG2+1)'(DEPTH / 2);

  typedef enum logic [1:0] {
    PRIME = 2'd0,
    IDLE  = 2'd1,
    PUSH  = 2'd2,
    WAIT  = 2'd3
  } state_t;

  state_t                  state;
  logic [W-1:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic [DEPTH_LOG2:0]     level;
  logic                    out_wreq;
  logic [W-1:0]            out_sample;
  logic                    underrun;
  logic                    in_ready;
  logic                    wr_en;
  logic                    pop;
  logic [W-1:0]            underrun_word;

  // Ready depends only on registered occupancy, never on the sink side.
  assign in_ready = (level != LEVEL_FULL);
  assign wr_en    = bus.in_valid && in_ready;
  assign pop      = (state == IDLE) && bus.sink_ready && (level != '0);

`ifdef AUDIO_FIFO_MUTE_ON_UNDERRUN_EN
  // Midscale on both channels silences the output on an empty buffer.
  assign underrun_word = {2{1'b1, {(AUDIO_BITS-1){1'b0}}}};
`else
  // Repeating the last word keeps the output stage steady on an empty buffer.
  assign underrun_word = out_sample;
`endif

  // Sample storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.in_sample;
  end

  // Pointers and occupancy; a write and a pop together leave level unchanged.
  always_ff @(posedge clk or negedge aclr_) begin
    if (!aclr_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Read FSM with registered out_wreq, out_sample and underrun.
  always_ff @(posedge clk or negedge aclr_) begin
    if (!aclr_) begin
      state      <= PRIME;
      out_wreq   <= 1'b0;
      out_sample <= '0;
      underrun   <= 1'b0;
    end else begin
      case (state)
        PRIME: begin
          out_wreq <= 1'b0;
          underrun <= 1'b0;
          if (level >= LEVEL_PRIME) state <= IDLE;
        end
        IDLE: begin
          if (bus.sink_ready) begin
            state    <= PUSH;
            out_wreq <= 1'b1;
            if (level != '0) begin
              out_sample <= mem[rd_ptr];
              underrun   <= 1'b0;
            end else begin
              out_sample <= underrun_word;
              underrun   <= 1'b1;
            end
          end else begin
            out_wreq <= 1'b0;
            underrun <= 1'b0;
          end
        end
        PUSH: begin
          state    <= WAIT;
          out_wreq <= 1'b0;
          underrun <= 1'b0;
        end
        WAIT: begin
          out_wreq <= 1'b0;
          underrun <= 1'b0;
          if (!bus.sink_ready) state <= IDLE;
        end
        default: begin
          state    <= PRIME;
          out_wreq <= 1'b0;
          underrun <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_wreq   = out_wreq;
  assign bus.out_sample = out_sample;
  assign bus.level      = level;
  assign bus.underrun   = underrun;
  assign fsm_state      = state;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Bench for audio_sample_fifo at AUDIO_BITS=12, DEPTH_LOG2=4. Directed
// sequences push the words the output stage should receive into a queue;
// a negedge monitor pops and compares on every out_wreq.
module tb_audio_sample_fifo;

  localparam int AB = 12;
  localparam int DL = 4;
  localparam int W  = 2 * AB;

  localparam logic [1:0] S_PRIME = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd3;
  localparam logic [W-1:0] MUTE_WORD = 24'h800800;

  logic       clk = 1'b0;
  logic       aclr_;
  logic [1:0] fsm_state;

  int checks   = 0;
  int failures = 0;
  int wreq_count = 0;
  int saved_count;

  logic [W-1:0] exp_q[$];
  logic         exp_ur_q[$];

  // Clock and reset block.
  always #5 clk = ~clk;

  audio_sample_fifo_if #(.AUDIO_BITS(AB), .DEPTH_LOG2(DL)) bus();

  audio_sample_fifo #(.AUDIO_BITS(AB), .DEPTH_LOG2(DL)) dut (
    .clk       (clk),
    .aclr_     (aclr_),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // Distinctive stereo word for test t, index k.
  function automatic logic [W-1:0] mk(input int t, input int k);
    logic [3:0] tt;
    logic [7:0] kk;
    tt = 4'(t);
    kk = 8'(k);
    return {tt, kk, tt ^ 4'hF, kk ^ 8'hFF};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write request must match the queue head.
  always @(negedge clk) begin
    if (bus.out_wreq === 1'b1) begin
      wreq_count++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_wreq: got sample %0h with nothing expected", bus.out_sample);
      end else begin
        logic [W-1:0] es;
        logic         eu;
        es = exp_q.pop_front();
        eu = exp_ur_q.pop_front();
        if (bus.out_sample !== es || bus.underrun !== eu) begin
          failures++;
          $display("FAIL wreq_word: got sample %0h underrun %0b expected sample %0h underrun %0b",
                   bus.out_sample, bus.underrun, es, eu);
        end
      end
    end
  end

  // Driver tasks.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_word(input logic [W-1:0] w);
    bus.in_valid  = 1'b1;
    bus.in_sample = w;
    step(1);
    bus.in_valid  = 1'b0;
  endtask

  task automatic expect_word(input logic [W-1:0] w, input logic ur);
    exp_q.push_back(w);
    exp_ur_q.push_back(ur);
  endtask

  // One full sink_ready period: low long enough to re-arm, then high.
  task automatic pulse_sink();
    bus.sink_ready = 1'b0;
    step(2);
    bus.sink_ready = 1'b1;
    step(2);
    bus.sink_ready = 1'b0;
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic apply_reset(input string tag);
    #2 aclr_ = 1'b0;
    #1;
    check({tag, "_rst_level"},      32'(bus.level), 32'd0);
    check({tag, "_rst_state"},      32'(fsm_state), 32'(S_PRIME));
    check({tag, "_rst_wreq"},       32'(bus.out_wreq), 32'd0);
    check({tag, "_rst_sample"},     32'(bus.out_sample), 32'd0);
    check({tag, "_rst_underrun"},   32'(bus.underrun), 32'd0);
    check({tag, "_rst_in_ready"},   32'(bus.in_ready), 32'd1);
    step(1);
    aclr_ = 1'b1;
    step(1);
  endtask

  initial begin
    aclr_         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sample = '0;
    bus.sink_ready = 1'b0;
    step(2);
    check("init_level",    32'(bus.level), 32'd0);
    check("init_state",    32'(fsm_state), 32'(S_PRIME));
    check("init_wreq",     32'(bus.out_wreq), 32'd0);
    check("init_sample",   32'(bus.out_sample), 32'd0);
    check("init_in_ready", 32'(bus.in_ready), 32'd1);
    aclr_ = 1'b1;
    step(1);

    // Priming threshold, held sink_ready, then drain into an underrun.
    bus.sink_ready = 1'b1;
    for (int k = 1; k <= 7; k++) write_word(mk(2, k));
    step(3);
    check("prime_level7", 32'(bus.level), 32'd7);
    check("prime_state7", 32'(fsm_state), 32'(S_PRIME));
    check("prime_no_wreq", 32'(wreq_count), 32'd0);
    expect_word(mk(2, 1), 1'b0);
    write_word(mk(2, 8));
    step(4);
    check("first_wreq_count", 32'(wreq_count), 32'd1);
    check("first_level", 32'(bus.level), 32'd7);
    check("first_state_wait", 32'(fsm_state), 32'(S_WAIT));
    step(4);
    check("held_ready_one_wreq", 32'(wreq_count), 32'd1);
    for (int k = 2; k <= 8; k++) begin
      expect_word(mk(2, k), 1'b0);
      pulse_sink();
    end
    check("drained_level", 32'(bus.level), 32'd0);
`ifdef AUDIO_FIFO_MUTE_ON_UNDERRUN_EN
    expect_word(MUTE_WORD, 1'b1);
`else
    expect_word(mk(2, 8), 1'b1);
`endif
    pulse_sink();
    check("underrun_wreq_count", 32'(wreq_count), 32'd9);
    step(2);
    check("underrun_pulse_gone", 32'(bus.underrun), 32'd0);

    // Fill to full, ignored extra write, full read-back order.
    apply_reset("full");
    for (int k = 1; k <= 16; k++) write_word(mk(3, k));
    check("full_level", 32'(bus.level), 32'd16);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    write_word(mk(3, 99));
    step(1);
    check("full_level_after_extra", 32'(bus.level), 32'd16);
    check("full_state_idle", 32'(fsm_state), 32'(S_IDLE));
    for (int k = 1; k <= 16; k++) begin
      expect_word(mk(3, k), 1'b0);
      pulse_sink();
    end
    check("full_drained_level", 32'(bus.level), 32'd0);
    check("full_drained_in_ready", 32'(bus.in_ready), 32'd1);

    // Simultaneous write and pop at level 5 with write pointer at 15.
    apply_reset("wrap");
    for (int k = 1; k <= 8; k++) write_word(mk(4, k));
    step(2);
    for (int k = 1; k <= 3; k++) begin
      expect_word(mk(4, k), 1'b0);
      pulse_sink();
    end
    check("wrap_level5a", 32'(bus.level), 32'd5);
    for (int k = 9; k <= 15; k++) write_word(mk(4, k));
    for (int k = 4; k <= 10; k++) begin
      expect_word(mk(4, k), 1'b0);
      pulse_sink();
    end
    check("wrap_level5b", 32'(bus.level), 32'd5);
    expect_word(mk(4, 11), 1'b0);
    bus.sink_ready = 1'b0;
    step(2);
    bus.sink_ready = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_sample  = mk(4, 16);
    step(1);
    bus.in_valid   = 1'b0;
    check("wrap_same_edge_level", 32'(bus.level), 32'd5);
    step(1);
    bus.sink_ready = 1'b0;
    write_word(mk(4, 17));
    check("wrap_level6", 32'(bus.level), 32'd6);
    for (int k = 12; k <= 17; k++) begin
      expect_word(mk(4, k), 1'b0);
      pulse_sink();
    end
    check("wrap_drained_level", 32'(bus.level), 32'd0);

    // Reset while waiting with ten words buffered.
    apply_reset("mid");
    for (int k = 1; k <= 11; k++) write_word(mk(5, k));
    step(2);
    expect_word(mk(5, 1), 1'b0);
    pulse_sink();
    check("mid_level10", 32'(bus.level), 32'd10);
    check("mid_state_wait", 32'(fsm_state), 32'(S_WAIT));
    saved_count = wreq_count;
    apply_reset("mid");
    bus.sink_ready = 1'b1;
    step(6);
    check("mid_no_wreq_after_reset", 32'(wreq_count), 32'(saved_count));
    check("mid_state_prime", 32'(fsm_state), 32'(S_PRIME));
    check("mid_level_zero", 32'(bus.level), 32'd0);
    bus.sink_ready = 1'b0;

    step(2);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
